matmul_k_partial_accumulator: RTL and testbench

// - Sits directly downstream of the large-K matmul stage.
// - The matmul stage splits K into NUM_TILES tiles and emits one signed 32-bit partial dot product per tile.
// - This block sums the NUM_TILES partials into one final C element.
// - It presents the element on a valid/ready output with one-entry holding, and flags malformed tile sequences.

---
 rtl/matmul_k_partial_accumulator.sv | 142 ++++++++++++++
 tb/tb_matmul_k_partial_accumulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_k_partial_accumulator.sv
// Sums NUM_TILES signed partial dot products into one C element and offers it on a
// valid/ready output with a one-entry hold. Optional macro: KACC_SATURATE_EN (clamp instead of wrap).
module matmul_k_partial_accumulator #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 48,
    parameter int NUM_TILES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic [DATA_W-1:0] partial_in,
    input  logic              last_in,
    output logic              valid_out,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              err_len
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_TILES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]               tile_cnt_q, tile_cnt_d;
    logic [DATA_W-1:0]         result_q, result_d;
    logic                      valid_out_q, valid_out_d;
    logic                      err_len_q, err_len_d;

    logic                      accept_s;
    logic                      final_s;
    logic signed [ACC_W-1:0]   part_ext_s;
    logic signed [ACC_W-1:0]   sum_s;

    // Narrow the wide sum to the output width (clamp or two's-complement wrap).
    function automatic logic [DATA_W-1:0] fmt(input logic signed [ACC_W-1:0] sum);
`ifdef KACC_SATURATE_EN
        if (sum > SAT_MAX) begin
            fmt = SAT_MAX[DATA_W-1:0];
        end else if (sum < SAT_MIN) begin
            fmt = SAT_MIN[DATA_W-1:0];
        end else begin
            fmt = DATA_W'(sum);
        end
`else
        fmt = DATA_W'(sum);
`endif
    endfunction

    assign in_ready   = (state_q == ST_ACCUM) || out_ready;
    assign accept_s   = valid_in && in_ready;
    assign final_s    = (tile_cnt_q == LAST_IDX);
    assign part_ext_s = {{(ACC_W-DATA_W){partial_in[DATA_W-1]}}, partial_in};
    assign sum_s      = acc_q + part_ext_s;

    assign valid_out  = valid_out_q;
    assign result     = result_q;
    assign err_len    = err_len_q;

    // Next-state: accumulation, element boundary by tile count, hold/handoff, framing check.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tile_cnt_d  = tile_cnt_q;
        result_d    = result_q;
        valid_out_d = valid_out_q;
        err_len_d   = err_len_q;

        // last_in is only checked; the tile count alone decides where an element ends.
        if (accept_s && (last_in != final_s)) begin
            err_len_d = 1'b1;
        end else begin
            err_len_d = err_len_q;
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept_s && final_s) begin
                    result_d    = fmt(sum_s);
                    valid_out_d = 1'b1;
                    acc_d       = '0;
                    tile_cnt_d  = 16'd0;
                    state_d     = ST_HOLD;
                end else if (accept_s) begin
                    acc_d      = sum_s;
                    tile_cnt_d = tile_cnt_q + 16'd1;
                end else begin
                    acc_d      = acc_q;
                    tile_cnt_d = tile_cnt_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_out_d = 1'b0;
                    state_d     = ST_ACCUM;
                    // A beat accepted during handoff opens the next element.
                    if (accept_s) begin
                        acc_d      = part_ext_s;
                        tile_cnt_d = 16'd1;
                    end else begin
                        acc_d      = acc_q;
                        tile_cnt_d = tile_cnt_q;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                acc_d       = '0;
                tile_cnt_d  = 16'd0;
                valid_out_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            tile_cnt_q  <= 16'd0;
            result_q    <= '0;
            valid_out_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tile_cnt_q  <= tile_cnt_d;
            result_q    <= result_d;
            valid_out_q <= valid_out_d;
            err_len_q   <= err_len_d;
        end
    end

endmodule

// File: tb/tb_matmul_k_partial_accumulator.sv
// Randomised and directed bench for matmul_k_partial_accumulator (NUM_TILES=4); expected
// results come from plain element sums kept in a queue.
module tb_matmul_k_partial_accumulator;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        in_ready;
    logic [31:0] partial_in = 32'd0;
    logic        last_in = 1'b0;
    logic        valid_out;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        err_len;

    matmul_k_partial_accumulator #(.DATA_W(32), .ACC_W(48), .NUM_TILES(NT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
        .partial_in(partial_in), .last_in(last_in), .valid_out(valid_out),
        .out_ready(out_ready), .result(result), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          rise;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc_n  = 0;
    int     pos    = 0;
    longint sum    = 0;
    logic   err_model = 1'b0;
    int     bp_mode = 0;
    bit     presenting = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] fmt_model(input longint s);
        logic [63:0] w;
        w = s;
`ifdef KACC_SATURATE_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) return 32'h8000_0000;
        else return w[31:0];
`else
        return w[31:0];
`endif
    endfunction

    // Offer one partial; return once accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic lst);
        int waited;
        @(negedge clk);
        valid_in   = 1'b1;
        partial_in = d;
        last_in    = lst;
        #1;
        waited = 0;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 200) begin
                chk("send_timeout", 64'd0, 64'd1);
                valid_in = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (lst != (pos == NT - 1)) err_model = 1'b1;
        sum += longint'($signed(d));
        if (pos == NT - 1) begin
            exp_q.push_back('{val: fmt_model(sum), rise: cyc_n + 1});
            sum = 0;
            pos = 0;
        end else begin
            pos++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic send_elem(input logic [31:0] d0, d1, d2, d3, input int last_at);
        send(d0, last_at == 0);
        send(d1, last_at == 1);
        send(d2, last_at == 2);
        send(d3, last_at == 3);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(valid_out), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_err"}, 64'(err_len), 64'd0);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Downstream ready pattern.
    initial begin
        forever begin
            @(negedge clk);
            if (bp_mode == 0) out_ready = 1'b1;
            else if (bp_mode == 1) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor against the expected-element queue.
    initial begin
        bit v_exp;
        forever begin
            @(negedge clk);
            cyc_n++;
            #2;
            if (rst) begin
                presenting = 1'b0;
                continue;
            end
            v_exp = presenting || (exp_q.size() > 0 && exp_q[0].rise <= cyc_n);
            chk("valid_out", 64'(valid_out), 64'(v_exp));
            chk("in_ready", 64'(in_ready), 64'(!v_exp || out_ready));
            chk("err_len", 64'(err_len), 64'(err_model));
            if (v_exp && exp_q.size() > 0) begin
                chk("result", 64'(result), 64'(exp_q[0].val));
                presenting = 1'b1;
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    presenting = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("reset");

        // Basic sum 1..4.
        send_elem(32'd1, 32'd2, 32'd3, 32'd4, 3);
        idle(3);

        // Backpressure with the next element already waiting.
        bp_mode = 1;
        send_elem(32'd5, 32'd5, 32'd5, 32'd5, 3);
        fork
            send_elem(32'd1, 32'd1, 32'd1, 32'd1, 3);
            begin
                repeat (6) @(negedge clk);
                bp_mode = 0;
            end
        join
        idle(3);

        // Signed extremes.
        send_elem(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3);
        send_elem(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3);
        idle(3);

        // Framing error: last_in on the second beat.
        send_elem(32'd1, 32'd1, 32'd1, 32'd1, 1);
        idle(4);

        // Reset in the middle of an element.
        send(32'd7, 1'b0);
        send(32'd7, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        pos = 0;
        sum = 0;
        err_model = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        send_elem(32'd1, 32'd2, 32'd3, 32'd4, 3);
        idle(2);

        // Three elements streamed back to back.
        for (int e = 0; e < 3; e++) begin
            send_elem(32'(e * 10 + 1), 32'(e * 10 + 2), 32'hFFFF_FFFF, 32'(e), 3);
        end
        idle(3);

        // Random traffic, backpressure and occasional bad framing.
        bp_mode = 2;
        for (int e = 0; e < 40; e++) begin
            int bad;
            bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : 3;
            for (int b = 0; b < NT; b++) begin
                send($urandom, b == bad);
                if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        idle(1);
        bp_mode = 0;
        drain();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
